hazard_stall_ctrl: RTL

//  Hazard/stall controller for the 5-stage pipeline. Compares D-stage source

---
 rtl/hazard_stall_ctrl_pkg.sv | 46 ++++
 rtl/hazard_stall_ctrl_if.sv | 35 +++
 rtl/hazard_stall_ctrl_md_busy_counter.sv | 38 +++
 rtl/hazard_stall_ctrl.sv | 64 ++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions: register indices, Tuse/Tnew codes, mult/div latencies.
package hazard_stall_ctrl_pkg;

  localparam int unsigned REG_W        = 5;
  localparam int unsigned TCODE_W      = 2;
  localparam int unsigned STALL_CNT_W  = 16;
  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;
  localparam int unsigned CNT_W_DEF    = 4;

  typedef logic [REG_W-1:0]   reg_idx_t;
  typedef logic [TCODE_W-1:0] tcode_t;

  // Tuse/Tnew encoding: cycles until needed/available, 3 means "not used / none"
  typedef enum logic [TCODE_W-1:0] {
    TCODE_0    = 2'd0,
    TCODE_1    = 2'd1,
    TCODE_2    = 2'd2,
    TCODE_NONE = 2'd3
  } tcode_e;

  localparam reg_idx_t REG_ZERO = '0;

  // D-stage source operand request
  typedef struct packed {
    reg_idx_t idx;
    tcode_t   tuse;
  } src_req_t;

  // Later-stage destination producer
  typedef struct packed {
    reg_idx_t a3;
    tcode_t   tnew;
  } dst_prod_t;

  // True when a source needs its value before an in-flight producer can supply it
  function automatic logic src_hazard(input src_req_t src, input dst_prod_t e,
                                      input dst_prod_t m);
    logic hit_e;
    logic hit_m;
    hit_e = (src.idx == e.a3) && (src.tuse < e.tnew);
    hit_m = (src.idx == m.a3) && (src.tuse < m.tnew);
    return (src.idx != REG_ZERO) && (hit_e || hit_m);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
interface hazard_stall_ctrl_if;
  import hazard_stall_ctrl_pkg::*;

  reg_idx_t                 rs_D;
  reg_idx_t                 rt_D;
  tcode_t                   tuse_rs_D;
  tcode_t                   tuse_rt_D;
  logic                     md_use_D;
  reg_idx_t                 a3_E;
  tcode_t                   tnew_E;
  reg_idx_t                 a3_M;
  tcode_t                   tnew_M;
  logic                     md_start_E;
  logic                     md_is_div_E;
  logic                     stall;
  logic                     flush_E;
  logic                     md_busy;
  logic [STALL_CNT_W-1:0]   stall_cnt;

  // Pipeline side: presents stage information, receives stall controls
  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D,
    output a3_E, tnew_E, a3_M, tnew_M, md_start_E, md_is_div_E,
    input  stall, flush_E, md_busy, stall_cnt
  );

  // Controller side
  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D,
    input  a3_E, tnew_E, a3_M, tnew_M, md_start_E, md_is_div_E,
    output stall, flush_E, md_busy, stall_cnt
  );

endinterface

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// Tracks the multi-cycle mult/div unit; busy for exactly N cycles after a start.
module hazard_stall_ctrl_md_busy_counter #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  // Load on an accepted start; a start while busy is dropped and the countdown continues
  always_comb begin
    count_nxt = count;
    if (start && (count == '0)) begin
      count_nxt = is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (count != '0) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Counter and registered busy flag (busy mirrors count != 0)
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      busy  <= 1'b0;
    end else begin
      count <= count_nxt;
      busy  <= (count_nxt != '0);
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: data hazards from D vs E/M, mult/div hazards, stall perf counter.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  hazard_stall_ctrl_if.slave bus
);

  src_req_t                src_rs;
  src_req_t                src_rt;
  dst_prod_t               prod_e;
  dst_prod_t               prod_m;
  logic                    stall_rs;
  logic                    stall_rt;
  logic                    stall_md;
  logic                    stall_c;
  logic                    md_busy;
  logic [STALL_CNT_W-1:0]  stall_cnt;

  // Hazard detection is purely combinational from the current stage contents
  always_comb begin
    src_rs   = '{idx: bus.rs_D, tuse: bus.tuse_rs_D};
    src_rt   = '{idx: bus.rt_D, tuse: bus.tuse_rt_D};
    prod_e   = '{a3: bus.a3_E, tnew: bus.tnew_E};
    prod_m   = '{a3: bus.a3_M, tnew: bus.tnew_M};
    stall_rs = src_hazard(src_rs, prod_e, prod_m);
    stall_rt = src_hazard(src_rt, prod_e, prod_m);
    stall_md = bus.md_use_D && (md_busy || bus.md_start_E);
    stall_c  = stall_rs || stall_rt || stall_md;
  end

  hazard_stall_ctrl_md_busy_counter #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_md_busy (
    .clk    (clk),
    .reset  (reset),
    .start  (bus.md_start_E),
    .is_div (bus.md_is_div_E),
    .busy   (md_busy)
  );

  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_c && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

  // Bubble insertion into D/E coincides with the freeze of PC and F/D
  assign bus.stall     = stall_c;
  assign bus.flush_E   = stall_c;
  assign bus.md_busy   = md_busy;
  assign bus.stall_cnt = stall_cnt;

endmodule
